// File: rtl/pipe_idex_skid_pkg.sv
// Shared core package for the ID/EX stage register.
// Holds the control-field enums used between decode and EX, the
// IDEXPipelineType payload carried through the stage, its reset value,
// and the occupancy state encoding of the skid buffer.
package pipe_idex_skid_pkg;

  localparam int CORE_XLEN    = 32;
  localparam int CORE_RADDR_W = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } AluOp;

  typedef enum logic {
    OF_ALU_A_RS1 = 1'b0,
    OF_ALU_A_PC  = 1'b1
  } OpASel;

  typedef enum logic {
    OF_ALU_B_RS2 = 1'b0,
    OF_ALU_B_IMM = 1'b1
  } OpBSel;

  typedef enum logic [1:0] {
    WB_SEL_ALU = 2'd0,
    WB_SEL_MEM = 2'd1,
    WB_SEL_PC4 = 2'd2,
    WB_SEL_CSR = 2'd3
  } WbSel;

  // One ID/EX entry, already forwarded and operand-selected.
  typedef struct packed {
    AluOp                    aluControl;
    logic [CORE_XLEN-1:0]    operandA;
    logic [CORE_XLEN-1:0]    operandB;
    logic [CORE_XLEN-1:0]    storeData;
    logic [CORE_XLEN-1:0]    pc;
    logic [CORE_RADDR_W-1:0] rdAddr;
    logic                    rdWriteEn;
    WbSel                    destinationSelect;
  } IDEXPipelineType;

  localparam IDEXPipelineType IDEX_RESET = '{
    aluControl:        ALU_ADD,
    operandA:          '0,
    operandB:          '0,
    storeData:         '0,
    pc:                '0,
    rdAddr:            '0,
    rdWriteEn:         1'b0,
    destinationSelect: WB_SEL_ALU
  };

  // Bit 0 is mainValid, bit 1 is skidValid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b01,
    ST_FULL  = 2'b11
  } SkidState;

endpackage

// File: rtl/pipe_idex_skid_fwd_mux.sv
// fwd_mux: priority operand bypass for one source register.
// Ports:
//   addr, reg_data          - source register address and register-file value
//   ex_mem_en/addr/data     - EX/MEM bypass (highest priority)
//   mem_wb_en/addr/data     - MEM/WB bypass
//   data                    - forwarded operand
// x0 is never bypassed, so a write-enabled x0 in a later stage cannot
// leak a non-zero value into a read of x0.
module fwd_mux #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic [RADDR_W-1:0] addr,
  input  logic [XLEN-1:0]    reg_data,
  input  logic               ex_mem_en,
  input  logic [RADDR_W-1:0] ex_mem_addr,
  input  logic [XLEN-1:0]    ex_mem_data,
  input  logic               mem_wb_en,
  input  logic [RADDR_W-1:0] mem_wb_addr,
  input  logic [XLEN-1:0]    mem_wb_data,
  output logic [XLEN-1:0]    data
);

  logic addr_nonzero;
  logic hit_ex_mem;
  logic hit_mem_wb;

  assign addr_nonzero = |addr;
  assign hit_ex_mem   = ex_mem_en && (ex_mem_addr == addr) && addr_nonzero;
  assign hit_mem_wb   = mem_wb_en && (mem_wb_addr == addr) && addr_nonzero;

  // The younger EX/MEM result wins over the older MEM/WB result.
  always_comb begin
    data = reg_data;
    if (hit_ex_mem) begin
      data = ex_mem_data;
    end else if (hit_mem_wb) begin
      data = mem_wb_data;
    end
  end

endmodule

// File: rtl/pipe_idex_skid.sv
// pipe_idex_skid: ID/EX stage register with valid/ready handshake.
// Ports:
//   clk, arstn (sync, active-low), flush (drops all held/accepted entries)
//   in_valid/in_ready       - decode-side handshake
//   aluControlIn, operandASelect, operandBSelect, rs1/rs2/rdAddr(In),
//   rs1Data, rs2Data, immediate, pcIn, rdWriteEnIn, destinationSelectIn
//                           - decoded instruction fields
//   fwdExMem*, fwdMemWb*    - bypass sources, sampled in the accept cycle
//   out_valid/out_ready     - EX-side handshake
//   aluControl, operandA, operandB, storeData, pc, rdAddr, rdWriteEn,
//   destinationSelect       - EX-side entry, driven only from main register
// SKID=1 adds a second entry so in_ready comes from a register and EX
// backpressure never forms a combinational path back into decode.
module pipe_idex_skid
  import pipe_idex_skid_pkg::*;
#(
  parameter int XLEN    = CORE_XLEN,
  parameter int RADDR_W = CORE_RADDR_W,
  parameter int SKID    = 1
) (
  input  logic               clk,
  input  logic               arstn,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  AluOp               aluControlIn,
  input  OpASel              operandASelect,
  input  OpBSel              operandBSelect,
  input  logic [RADDR_W-1:0] rs1Addr,
  input  logic [RADDR_W-1:0] rs2Addr,
  input  logic [RADDR_W-1:0] rdAddrIn,
  input  logic [XLEN-1:0]    rs1Data,
  input  logic [XLEN-1:0]    rs2Data,
  input  logic [XLEN-1:0]    immediate,
  input  logic [XLEN-1:0]    pcIn,
  input  logic               rdWriteEnIn,
  input  WbSel               destinationSelectIn,
  input  logic               fwdExMemEn,
  input  logic [RADDR_W-1:0] fwdExMemAddr,
  input  logic [XLEN-1:0]    fwdExMemData,
  input  logic               fwdMemWbEn,
  input  logic [RADDR_W-1:0] fwdMemWbAddr,
  input  logic [XLEN-1:0]    fwdMemWbData,
  output logic               out_valid,
  input  logic               out_ready,
  output AluOp               aluControl,
  output logic [XLEN-1:0]    operandA,
  output logic [XLEN-1:0]    operandB,
  output logic [XLEN-1:0]    storeData,
  output logic [XLEN-1:0]    pc,
  output logic [RADDR_W-1:0] rdAddr,
  output logic               rdWriteEn,
  output WbSel               destinationSelect
);

  localparam bit USE_SKID = (SKID != 0);

  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;

  IDEXPipelineType in_entry;
  IDEXPipelineType main_q;
  IDEXPipelineType skid_q;

  SkidState state_q;
  SkidState state_d;

  logic main_valid;
  logic in_fire;
  logic out_fire;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid;

  fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd_rs1 (
    .addr        (rs1Addr),
    .reg_data    (rs1Data),
    .ex_mem_en   (fwdExMemEn),
    .ex_mem_addr (fwdExMemAddr),
    .ex_mem_data (fwdExMemData),
    .mem_wb_en   (fwdMemWbEn),
    .mem_wb_addr (fwdMemWbAddr),
    .mem_wb_data (fwdMemWbData),
    .data        (fwd_rs1)
  );

  fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd_rs2 (
    .addr        (rs2Addr),
    .reg_data    (rs2Data),
    .ex_mem_en   (fwdExMemEn),
    .ex_mem_addr (fwdExMemAddr),
    .ex_mem_data (fwdExMemData),
    .mem_wb_en   (fwdMemWbEn),
    .mem_wb_addr (fwdMemWbAddr),
    .mem_wb_data (fwdMemWbData),
    .data        (fwd_rs2)
  );

  // Build the entry as it will be captured; forwarding is frozen here.
  always_comb begin
    in_entry                   = IDEX_RESET;
    in_entry.aluControl        = aluControlIn;
    in_entry.operandA          = (operandASelect == OF_ALU_A_RS1) ? fwd_rs1 : pcIn;
    in_entry.operandB          = (operandBSelect == OF_ALU_B_RS2) ? fwd_rs2 : immediate;
    in_entry.storeData         = fwd_rs2;
    in_entry.pc                = pcIn;
    in_entry.rdAddr            = rdAddrIn;
    in_entry.rdWriteEn         = rdWriteEnIn;
    in_entry.destinationSelect = destinationSelectIn;
  end

  assign main_valid = (state_q != ST_EMPTY);
  assign in_fire    = in_valid && in_ready;
  assign out_fire   = main_valid && out_ready;

  generate
    if (USE_SKID) begin : g_ready_skid
      assign in_ready = arstn && (state_q != ST_FULL);
    end else begin : g_ready_single
      assign in_ready = arstn && (!main_valid || out_ready);
    end
  endgenerate

  // Occupancy next-state and payload steering. In single-register mode an
  // accept in BUSY always coincides with a release, so FULL is unreachable.
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            load_main_in = 1'b1;
            state_d      = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end else if (in_fire && USE_SKID) begin
            load_skid = 1'b1;
            state_d   = ST_FULL;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            load_main_skid = 1'b1;
            state_d        = ST_BUSY;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // State and main register; reset outranks flush.
  always_ff @(posedge clk) begin
    if (!arstn) begin
      state_q <= ST_EMPTY;
      main_q  <= IDEX_RESET;
    end else begin
      state_q <= state_d;
      if (load_main_in) begin
        main_q <= in_entry;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
    end
  end

  // Skid payload needs no reset: it is only read when FULL.
  always_ff @(posedge clk) begin
    if (load_skid) begin
      skid_q <= in_entry;
    end
  end

  assign out_valid         = main_valid;
  assign aluControl        = main_q.aluControl;
  assign operandA          = main_q.operandA;
  assign operandB          = main_q.operandB;
  assign storeData         = main_q.storeData;
  assign pc                = main_q.pc;
  assign rdAddr            = main_q.rdAddr;
  assign rdWriteEn         = main_q.rdWriteEn;
  assign destinationSelect = main_q.destinationSelect;

endmodule

// File: tb/tb_pipe_idex_skid.sv
// Scoreboard bench for pipe_idex_skid. One instance uses the skid buffer,
// a second uses the single-register mode. The driver pushes the expected
// entry whenever a vector is accepted; a forked monitor pops and compares
// whenever an output is released.
module tb_pipe_idex_skid;
  import pipe_idex_skid_pkg::*;

  typedef struct {
    AluOp        alu;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm, pc;
    OpASel       sa;
    OpBSel       sb;
    logic        we;
    WbSel        dest;
    logic        exEn;
    logic [4:0]  exAddr;
    logic [31:0] exData;
    logic        mwEn;
    logic [4:0]  mwAddr;
    logic [31:0] mwData;
    logic [31:0] expA, expB, expS;
  } vec_t;

  typedef struct packed {
    AluOp        alu;
    logic [31:0] a, b, s, pc;
    logic [4:0]  rd;
    logic        we;
    WbSel        dest;
  } exp_t;

  logic clk;
  logic arstn, flush, flush0;
  logic in_valid, in_valid0, out_ready, out_ready0;
  AluOp aluControlIn;
  OpASel operandASelect;
  OpBSel operandBSelect;
  logic [4:0] rs1Addr, rs2Addr, rdAddrIn;
  logic [31:0] rs1Data, rs2Data, immediate, pcIn;
  logic rdWriteEnIn;
  WbSel destinationSelectIn;
  logic fwdExMemEn, fwdMemWbEn;
  logic [4:0] fwdExMemAddr, fwdMemWbAddr;
  logic [31:0] fwdExMemData, fwdMemWbData;

  logic in_ready, out_valid, rdWriteEn;
  AluOp aluControl;
  logic [31:0] operandA, operandB, storeData, pc;
  logic [4:0] rdAddr;
  WbSel destinationSelect;

  logic in_ready0, out_valid0, rdWriteEn0;
  AluOp aluControl0;
  logic [31:0] operandA0, operandB0, storeData0, pc0;
  logic [4:0] rdAddr0;
  WbSel destinationSelect0;

  int errors;
  int checks;
  exp_t q1[$];
  exp_t q0[$];
  vec_t dirVec[6];

  pipe_idex_skid #(.XLEN(32), .RADDR_W(5), .SKID(1)) dut (
    .clk(clk), .arstn(arstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .aluControlIn(aluControlIn), .operandASelect(operandASelect), .operandBSelect(operandBSelect),
    .rs1Addr(rs1Addr), .rs2Addr(rs2Addr), .rdAddrIn(rdAddrIn),
    .rs1Data(rs1Data), .rs2Data(rs2Data), .immediate(immediate), .pcIn(pcIn),
    .rdWriteEnIn(rdWriteEnIn), .destinationSelectIn(destinationSelectIn),
    .fwdExMemEn(fwdExMemEn), .fwdExMemAddr(fwdExMemAddr), .fwdExMemData(fwdExMemData),
    .fwdMemWbEn(fwdMemWbEn), .fwdMemWbAddr(fwdMemWbAddr), .fwdMemWbData(fwdMemWbData),
    .out_valid(out_valid), .out_ready(out_ready),
    .aluControl(aluControl), .operandA(operandA), .operandB(operandB), .storeData(storeData),
    .pc(pc), .rdAddr(rdAddr), .rdWriteEn(rdWriteEn), .destinationSelect(destinationSelect)
  );

  pipe_idex_skid #(.XLEN(32), .RADDR_W(5), .SKID(0)) dut0 (
    .clk(clk), .arstn(arstn), .flush(flush0),
    .in_valid(in_valid0), .in_ready(in_ready0),
    .aluControlIn(aluControlIn), .operandASelect(operandASelect), .operandBSelect(operandBSelect),
    .rs1Addr(rs1Addr), .rs2Addr(rs2Addr), .rdAddrIn(rdAddrIn),
    .rs1Data(rs1Data), .rs2Data(rs2Data), .immediate(immediate), .pcIn(pcIn),
    .rdWriteEnIn(rdWriteEnIn), .destinationSelectIn(destinationSelectIn),
    .fwdExMemEn(fwdExMemEn), .fwdExMemAddr(fwdExMemAddr), .fwdExMemData(fwdExMemData),
    .fwdMemWbEn(fwdMemWbEn), .fwdMemWbAddr(fwdMemWbAddr), .fwdMemWbData(fwdMemWbData),
    .out_valid(out_valid0), .out_ready(out_ready0),
    .aluControl(aluControl0), .operandA(operandA0), .operandB(operandB0), .storeData(storeData0),
    .pc(pc0), .rdAddr(rdAddr0), .rdWriteEn(rdWriteEn0), .destinationSelect(destinationSelect0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t makeVec(AluOp alu, logic [4:0] rs1, logic [31:0] d1,
                                   logic [4:0] rs2, logic [31:0] d2, logic [31:0] imm,
                                   logic [31:0] pcv, OpASel sa, OpBSel sb,
                                   logic [31:0] ea, logic [31:0] eb, logic [31:0] es);
    vec_t v;
    v.alu = alu; v.rs1 = rs1; v.d1 = d1; v.rs2 = rs2; v.d2 = d2; v.imm = imm;
    v.pc = pcv; v.sa = sa; v.sb = sb; v.rd = 5'd9; v.we = 1'b1; v.dest = WB_SEL_ALU;
    v.exEn = 1'b0; v.exAddr = 5'd0; v.exData = 32'd0;
    v.mwEn = 1'b0; v.mwAddr = 5'd0; v.mwData = 32'd0;
    v.expA = ea; v.expB = eb; v.expS = es;
    return v;
  endfunction

  // Plain entry with no forwarding: A = rs1Data, B = immediate.
  function automatic vec_t makeSimple(int idx, AluOp alu);
    vec_t v;
    v = makeVec(alu, 5'd1, 32'h100 + idx, 5'd2, 32'h200 + idx, 32'(idx), 32'h1000 + 4 * idx,
                OF_ALU_A_RS1, OF_ALU_B_IMM, 32'h100 + idx, 32'(idx), 32'h200 + idx);
    v.rd = 5'(idx);
    v.we = idx[0];
    v.dest = WB_SEL_MEM;
    return v;
  endfunction

  function automatic exp_t expOf(vec_t v);
    exp_t e;
    e.alu = v.alu; e.a = v.expA; e.b = v.expB; e.s = v.expS; e.pc = v.pc;
    e.rd = v.rd; e.we = v.we; e.dest = v.dest;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drivePayload(input vec_t v);
    aluControlIn = v.alu; operandASelect = v.sa; operandBSelect = v.sb;
    rs1Addr = v.rs1; rs2Addr = v.rs2; rdAddrIn = v.rd;
    rs1Data = v.d1; rs2Data = v.d2; immediate = v.imm; pcIn = v.pc;
    rdWriteEnIn = v.we; destinationSelectIn = v.dest;
    fwdExMemEn = v.exEn; fwdExMemAddr = v.exAddr; fwdExMemData = v.exData;
    fwdMemWbEn = v.mwEn; fwdMemWbAddr = v.mwAddr; fwdMemWbData = v.mwData;
  endtask

  // Present a vector until accepted; called and returns at posedge+1.
  task automatic applyStimulus(input vec_t v, input bit toDut0, input bit toggle);
    bit acc;
    int n;
    drivePayload(v);
    if (toDut0) in_valid0 = 1'b1; else in_valid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 20) begin
      if (toggle) out_ready0 = !out_ready0;
      @(negedge clk);
      #1;
      acc = toDut0 ? in_ready0 : in_ready;
      if (acc) begin
        if (toDut0) q0.push_back(expOf(v));
        else q1.push_back(expOf(v));
      end
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: pc %h never accepted within %0d cycles", v.pc, n);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: occupancy/ready model per DUT, then pop on every release.
  task automatic monitorLoop();
    exp_t e;
    exp_t act;
    forever begin
      @(negedge clk);
      checkOutput("in_ready_skid", 32'(in_ready), 32'(arstn && (q1.size() < 2)));
      checkOutput("out_valid_skid", 32'(out_valid), 32'(q1.size() != 0));
      if (out_valid && out_ready) begin
        act = '{alu: aluControl, a: operandA, b: operandB, s: storeData, pc: pc,
                rd: rdAddr, we: rdWriteEn, dest: destinationSelect};
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_skid: got %h expected nothing", act);
        end else begin
          e = q1.pop_front();
          if (act !== e) begin
            errors++;
            $display("[TB] FAIL entry_skid: got %h expected %h", act, e);
          end
        end
      end
      checkOutput("in_ready_single", 32'(in_ready0), 32'(arstn && (q0.size() == 0 || out_ready0)));
      checkOutput("out_valid_single", 32'(out_valid0), 32'(q0.size() != 0));
      if (out_valid0 && out_ready0) begin
        act = '{alu: aluControl0, a: operandA0, b: operandB0, s: storeData0, pc: pc0,
                rd: rdAddr0, we: rdWriteEn0, dest: destinationSelect0};
        checks++;
        if (q0.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_single: got %h expected nothing", act);
        end else begin
          e = q0.pop_front();
          if (act !== e) begin
            errors++;
            $display("[TB] FAIL entry_single: got %h expected %h", act, e);
          end
        end
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    arstn = 1'b0; flush = 1'b0; flush0 = 1'b0;
    in_valid = 1'b0; in_valid0 = 1'b0; out_ready = 1'b0; out_ready0 = 1'b1;
    drivePayload(makeSimple(0, ALU_ADD));

    // Directed vectors with hand-computed operands.
    dirVec[0] = makeVec(ALU_ADD, 5'd1, 32'd5, 5'd2, 32'd9, 32'd7, 32'h40,
                        OF_ALU_A_RS1, OF_ALU_B_IMM, 32'd5, 32'd7, 32'd9);
    dirVec[1] = makeVec(ALU_ADD, 5'd3, 32'h11, 5'd5, 32'h22, 32'd4, 32'h44,
                        OF_ALU_A_RS1, OF_ALU_B_IMM, 32'hAA, 32'd4, 32'h22);
    dirVec[1].exEn = 1'b1; dirVec[1].exAddr = 5'd3; dirVec[1].exData = 32'hAA;
    dirVec[1].mwEn = 1'b1; dirVec[1].mwAddr = 5'd3; dirVec[1].mwData = 32'hBB;
    dirVec[2] = makeVec(ALU_ADD, 5'd0, 32'h33, 5'd0, 32'h44, 32'd1, 32'h48,
                        OF_ALU_A_RS1, OF_ALU_B_RS2, 32'h33, 32'h44, 32'h44);
    dirVec[2].exEn = 1'b1; dirVec[2].exAddr = 5'd0; dirVec[2].exData = 32'hAA;
    dirVec[2].mwEn = 1'b1; dirVec[2].mwAddr = 5'd0; dirVec[2].mwData = 32'hBB;
    dirVec[3] = makeVec(ALU_SUB, 5'd3, 32'h55, 5'd6, 32'h66, 32'd2, 32'h4C,
                        OF_ALU_A_RS1, OF_ALU_B_RS2, 32'hBB, 32'hCC, 32'hCC);
    dirVec[3].exEn = 1'b1; dirVec[3].exAddr = 5'd6; dirVec[3].exData = 32'hCC;
    dirVec[3].mwEn = 1'b1; dirVec[3].mwAddr = 5'd3; dirVec[3].mwData = 32'hBB;
    dirVec[4] = makeVec(ALU_XOR, 5'd3, 32'h31, 5'd7, 32'h77, 32'h12, 32'h100,
                        OF_ALU_A_PC, OF_ALU_B_IMM, 32'h100, 32'h12, 32'hDD);
    dirVec[4].exEn = 1'b1; dirVec[4].exAddr = 5'd3; dirVec[4].exData = 32'hAA;
    dirVec[4].mwEn = 1'b1; dirVec[4].mwAddr = 5'd7; dirVec[4].mwData = 32'hDD;
    dirVec[5] = makeVec(ALU_OR, 5'd2, 32'h21, 5'd2, 32'h21, 32'd3, 32'h104,
                        OF_ALU_A_RS1, OF_ALU_B_RS2, 32'hBB, 32'hBB, 32'hBB);
    dirVec[5].exEn = 1'b0; dirVec[5].exAddr = 5'd2; dirVec[5].exData = 32'hAA;
    dirVec[5].mwEn = 1'b1; dirVec[5].mwAddr = 5'd2; dirVec[5].mwData = 32'hBB;

    fork
      monitorLoop();
    join_none

    // Reset values while arstn is held low.
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_aluControl", 32'(aluControl), 32'(ALU_ADD));
    checkOutput("rst_destSel", 32'(destinationSelect), 32'(WB_SEL_ALU));
    checkOutput("rst_operandA", operandA, 32'd0);
    checkOutput("rst_operandB", operandB, 32'd0);
    checkOutput("rst_storeData", storeData, 32'd0);
    checkOutput("rst_pc", pc, 32'd0);
    checkOutput("rst_rdAddr", 32'(rdAddr), 32'd0);
    checkOutput("rst_rdWriteEn", 32'(rdWriteEn), 32'd0);
    @(posedge clk);
    #1;
    arstn = 1'b1;
    @(negedge clk);
    checkOutput("in_ready_after_release", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // First transfer: one-cycle latency, A = 5, B = 7.
    out_ready = 1'b1;
    applyStimulus(dirVec[0], 1'b0, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("first_out_valid", 32'(out_valid), 32'd1);
    checkOutput("first_operandA", operandA, 32'd5);
    checkOutput("first_operandB", operandB, 32'd7);
    @(posedge clk);
    #1;

    // Forwarding vectors back to back at full throughput.
    for (int i = 1; i < 6; i++) applyStimulus(dirVec[i], 1'b0, 1'b0);
    in_valid = 1'b0;
    idle(3);

    // Backpressure: A held, B in skid, C refused until release.
    out_ready = 1'b0;
    applyStimulus(makeSimple(1, ALU_ADD), 1'b0, 1'b0);
    applyStimulus(makeSimple(2, ALU_SUB), 1'b0, 1'b0);
    drivePayload(makeSimple(3, ALU_AND));
    in_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checkOutput("full_in_ready", 32'(in_ready), 32'd0);
      checkOutput("full_hold_operandA", operandA, 32'h101);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    applyStimulus(makeSimple(3, ALU_AND), 1'b0, 1'b0);
    in_valid = 1'b0;
    idle(4);

    // Flush while FULL with a pending request.
    out_ready = 1'b0;
    applyStimulus(makeSimple(4, ALU_ADD), 1'b0, 1'b0);
    applyStimulus(makeSimple(5, ALU_ADD), 1'b0, 1'b0);
    drivePayload(makeSimple(6, ALU_ADD));
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    q1.delete();
    @(negedge clk);
    checkOutput("flush_full_out_valid", 32'(out_valid), 32'd0);
    checkOutput("flush_full_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    idle(3);

    // Flush in BUSY together with a real accept: both entries vanish.
    out_ready = 1'b0;
    applyStimulus(makeSimple(7, ALU_ADD), 1'b0, 1'b0);
    drivePayload(makeSimple(8, ALU_ADD));
    flush = 1'b1;
    @(negedge clk);
    checkOutput("flush_busy_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    q1.delete();
    @(negedge clk);
    checkOutput("flush_busy_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    idle(3);

    // One-cycle reset pulse while FULL with a pending request.
    out_ready = 1'b0;
    applyStimulus(makeSimple(9, ALU_SUB), 1'b0, 1'b0);
    applyStimulus(makeSimple(10, ALU_OR), 1'b0, 1'b0);
    drivePayload(makeSimple(11, ALU_XOR));
    arstn = 1'b0;
    @(negedge clk);
    checkOutput("pulse_in_ready", 32'(in_ready), 32'd0);
    checkOutput("pulse_aluControl_held", 32'(aluControl), 32'(ALU_SUB));
    @(posedge clk);
    #1;
    arstn = 1'b1;
    in_valid = 1'b0;
    q1.delete();
    @(negedge clk);
    checkOutput("post_pulse_out_valid", 32'(out_valid), 32'd0);
    checkOutput("post_pulse_aluControl", 32'(aluControl), 32'(ALU_ADD));
    checkOutput("post_pulse_operandA", operandA, 32'd0);
    checkOutput("post_pulse_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    idle(3);

    // Single-register mode: continuous stream, out_ready toggling.
    for (int i = 0; i < 8; i++) applyStimulus(makeSimple(20 + i, ALU_AND), 1'b1, 1'b1);
    in_valid0 = 1'b0;
    out_ready0 = 1'b1;
    idle(4);

    checkOutput("drain_skid", 32'(q1.size()), 32'd0);
    checkOutput("drain_single", 32'(q0.size()), 32'd0);

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_idex_skid.md
# pipe_idex_skid

Parametrised ID/EX stage register for the rv32imc core, sitting between decode and the ALU. It adds a valid/ready handshake with an optional two-entry skid buffer, a synchronous flush, and EX/MEM and MEM/WB operand forwarding ahead of operand selection. EX-side backpressure therefore stalls decode without a combinational ready path.

## Interface
Parameters:
- `XLEN`, default 32: datapath width of operands, pc, immediate and store data.
- `RADDR_W`, default 5: register address width.
- `SKID`, default 1: 1 selects the two-entry skid buffer with registered `in_ready`. 0 selects a single register with combinational `in_ready`.

Ports:
- `clk`, in, 1: clock. All state changes on the rising edge.
- `arstn`, in, 1: reset, synchronous, active-low.
- `flush`, in, 1: kills every held entry and any entry accepted in the same cycle.
- `in_valid` in 1, `in_ready` out 1: decode-side handshake.
- `aluControlIn` in `AluOp`; `operandASelect` in `OpASel`; `operandBSelect` in `OpBSel`.
- `rs1Addr`, `rs2Addr`, `rdAddrIn`: in, `RADDR_W` each.
- `rs1Data`, `rs2Data`, `immediate`, `pcIn`: in, `XLEN` each.
- `rdWriteEnIn` in 1; `destinationSelectIn` in `WbSel`.
- `fwdExMemEn` in 1, `fwdExMemAddr` in `RADDR_W`, `fwdExMemData` in `XLEN`: EX/MEM result bypass.
- `fwdMemWbEn` in 1, `fwdMemWbAddr` in `RADDR_W`, `fwdMemWbData` in `XLEN`: MEM/WB result bypass.
- `out_valid` out 1, `out_ready` in 1: EX-side handshake.
- `aluControl` out `AluOp`; `operandA`, `operandB`, `storeData`, `pc` out `XLEN`; `rdAddr` out `RADDR_W`; `rdWriteEn` out 1; `destinationSelect` out `WbSel`.

## Operation
- Accept: `in_fire = in_valid & in_ready`. Release: `out_fire = out_valid & out_ready`.
- Forwarding is evaluated combinationally in the accept cycle and captured with the entry. It is never re-evaluated while the entry is held; re-evaluation on stall is the hazard unit's responsibility.
- Forwarded rs1:
  - `fwdExMemData` if `fwdExMemEn`, `fwdExMemAddr == rs1Addr` and `rs1Addr != 0`.
  - Otherwise `fwdMemWbData` under the same rule with MEM/WB signals.
  - Otherwise `rs1Data`.
  - EX/MEM always has priority over MEM/WB. x0 is never forwarded.
- Forwarded rs2 uses the same rule with `rs2Addr`.
- `operandA` = forwarded rs1 if `operandASelect == OF_ALU_A_RS1`, else `pcIn`.
- `operandB` = forwarded rs2 if `operandBSelect == OF_ALU_B_RS2`, else `immediate`.
- `storeData` is always forwarded rs2.
- SKID=1 state machine; `skidValid` and `mainValid` together encode the state:
  - EMPTY:
    - On `in_fire`, load main and go to BUSY.
  - BUSY:
    - `in_fire & out_fire`: main reloads, stay in BUSY.
    - `out_fire` only: go to EMPTY.
    - `in_fire & !out_ready`: entry goes to skid, go to FULL.
  - FULL:
    - On `out_fire`, skid moves to main and the state goes to BUSY.
    - `in_ready = 0`, so no accept is possible.
  - `in_ready = arstn & !skidValid`, a registered term plus reset gating.
- SKID=0:
  - `in_ready = arstn & (!mainValid | out_ready)`.
  - Main reloads on `in_fire`.
  - `mainValid` clears on `out_fire & !in_fire`.
- Flush:
  - Next cycle `mainValid = 0` and `skidValid = 0`; the state is EMPTY.
  - An entry accepted in the flush cycle is discarded.
  - Payload registers may keep stale data.
- Reset has priority over flush.
- Reset values:
  - `out_valid` 0, `aluControl` ALU_ADD, `destinationSelect` WB_SEL_ALU.
  - `operandA`, `operandB`, `storeData`, `pc`, `rdAddr`, `rdWriteEn` all 0.
  - `in_ready` 0 while `arstn` is low, and 1 in the first cycle after release.
- Outputs are driven only from the main register. While `out_valid` is 1 they are stable until `out_fire`.

## Timing
- Latency: 1 cycle from `in_fire` into EMPTY to `out_valid = 1`.
- Throughput: 1 entry per cycle with `out_ready` held at 1, in both modes.
- SKID=1: `in_ready` falls the cycle after the first unreleased accept beyond main. It rises the cycle after `out_fire` from FULL.
- `out_valid` never drops without `out_fire`, flush or reset.
- Reset asserted mid-transfer: both entries are lost and the accept in that cycle is ignored.

## Structure
- Shared core package holds:
  - Enums: `AluOp` (ALU_ADD, …), `OpASel` (OF_ALU_A_RS1, OF_ALU_A_PC), `OpBSel` (OF_ALU_B_RS2, OF_ALU_B_IMM), `WbSel` (WB_SEL_ALU, …).
  - The `IDEXPipelineType` payload struct, parametrised by field width via package localparams.
- One sub-module: `fwd_mux`, instantiated twice for rs1 and rs2. It implements the priority bypass.

## Test plan
- Reset, then `in_valid` with `rs1Data = 5`, `immediate = 7`, `operandBSelect = IMM`, `out_ready = 1` → next cycle `out_valid = 1`, `operandA = 5`, `operandB = 7`.
- Forwarding with `rs1Addr = 3`, both bypasses enabled on x3 with EX/MEM data `0xAA` and MEM/WB data `0xBB` → `operandA = 0xAA`. Repeat with `rs1Addr = 0` → `rs1Data` passes unchanged.
- SKID=1 backpressure: `out_ready = 0`, stream A, B, C → A held at the outputs, B in skid, `in_ready = 0`, C not accepted. Raise `out_ready` → A, B, C emitted in order with no loss.
- Flush in FULL with an accept asserted → next cycle `out_valid = 0`, `in_ready = 1`, and nothing emitted afterwards.
- SKID=0, `out_ready` toggling every cycle under a continuous input stream → `in_ready` tracks `!mainValid | out_ready` combinationally, with no duplicates or drops.
- `arstn` pulsed low for 1 cycle while FULL → `out_valid = 0`, `aluControl = ALU_ADD`, and `in_ready = 0` during the pulse.
